ula_sched: RTL and testbench

//  Shares one ULA (ALU: A, B, OP[4:0] -> RESU, O/C/S/Z) between two requesters.

---
 rtl/ula_pkg.sv | 27 ++
 rtl/ula.sv | 59 +++++
 rtl/ula_rr_arb2.sv | 24 ++
 rtl/ula_sched.sv | 133 +++++++++++++
 tb/tb_ula_sched.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Shared types and constants for the ULA and its two-requester scheduler.
package ula_pkg;

    localparam int OPW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic o;
        logic c;
        logic s;
        logic z;
    } flags_t;

    localparam logic [OPW-1:0] OP_ADD    = 5'b00000;
    localparam logic [OPW-1:0] OP_ADDINC = 5'b00001;
    localparam logic [OPW-1:0] OP_INC    = 5'b00011;
    localparam logic [OPW-1:0] OP_SUBDEC = 5'b00100;
    localparam logic [OPW-1:0] OP_AND    = 5'b01000;
    localparam logic [OPW-1:0] OP_OR     = 5'b01001;
    localparam logic [OPW-1:0] OP_XOR    = 5'b01010;

endpackage

// File: rtl/ula.sv
// Combinational ULA: one adder shared by the arithmetic ops, plus bitwise ops.
// Unlisted opcodes pass operand A through; O and C are only meaningful for arithmetic.
module ula
    import ula_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] resu,
    output logic [3:0]       flags
);

    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic             arith;
    logic [WIDTH:0]   sum;
    flags_t           f;

    // Select the adder's second operand and carry-in for each arithmetic op
    always_comb begin
        b_eff = b;
        cin   = 1'b0;
        arith = 1'b1;
        case (op)
            OP_ADD:    ;
            OP_ADDINC: cin = 1'b1;
            OP_INC:    begin b_eff = '0; cin = 1'b1; end
            OP_SUBDEC: b_eff = ~b;
            default:   arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

    // Form the result and {O,C,S,Z}; overflow uses the effective second operand
    always_comb begin
        f    = '0;
        resu = a;
        if (arith) begin
            resu = sum[WIDTH-1:0];
            f.c  = sum[WIDTH];
            f.o  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else begin
            case (op)
                OP_AND:  resu = a & b;
                OP_OR:   resu = a | b;
                OP_XOR:  resu = a ^ b;
                default: resu = a;
            endcase
        end
        f.s = resu[WIDTH-1];
        f.z = (resu == '0);
    end

    assign flags = f;

endmodule

// File: rtl/ula_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time goes.
module ula_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] grant,
    output logic       gid
);

    // Pick the winner and drive a one-hot grant only when enabled
    always_comb begin
        gid = 1'b0;
        if (valid == 2'b11) begin
            gid = ~last_grant;
        end else if (valid[1]) begin
            gid = 1'b1;
        end
        grant = 2'b00;
        if (en && (valid != 2'b00)) begin
            grant = gid ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ula_sched.sv
// Shares one ULA between two valid/ready requesters. Operands are registered on
// accept, the ULA result is registered one cycle later, and the response is held
// until the consumer takes it, so one op completes at most every three cycles.
module ula_sched #(
    parameter int WIDTH = 16,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy
);

    import ula_pkg::*;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [1:0]       grant;
    logic             gid;
    logic [WIDTH-1:0] ula_resu;
    logic [3:0]       ula_flags;

    // Readies are suppressed while reset is held so no output leaks during reset
    ula_rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .en         ((state_q == IDLE) && !rst),
        .grant      (grant),
        .gid        (gid)
    );

    ula #(
        .WIDTH (WIDTH)
    ) u_ula (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .resu  (ula_resu),
        .flags (ula_flags)
    );

    // Next-state: accept in IDLE, capture ULA output in EXEC, hold response in RESP
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        flags_d      = flags_q;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    state_d      = EXEC;
                    last_grant_d = gid;
                    id_d         = gid;
                    op_d         = gid ? req1_op : req0_op;
                    a_d          = gid ? req1_a  : req0_a;
                    b_d          = gid ? req1_b  : req0_b;
                end
            end
            EXEC: begin
                result_d = ula_resu;
                flags_d  = ula_flags;
                state_d  = RESP;
            end
            RESP: begin
                // Clear on handshake so nothing from this op lingers into the next
                if (rsp_ready) begin
                    state_d  = IDLE;
                    id_d     = 1'b0;
                    result_d = '0;
                    flags_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; last_grant resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ula_sched.sv
// Directed bench for ula_sched: a 3-bit instance for most scenarios and a 16-bit
// instance for the sustained-throughput case. Inputs change just after the rising
// edge; outputs are sampled on the falling edge.
module tb_ula_sched;
    import ula_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int n_err = 0;
    int n_chk = 0;

    // 3-bit instance
    logic       r0v, r0r, r1v, r1r, rspv, rsprdy, rspid, busy;
    logic [4:0] r0op, r1op;
    logic [2:0] r0a, r0b, r1a, r1b, rspres;
    logic [3:0] rspfl;

    // 16-bit instance
    logic        w_r0v, w_r0r, w_r1v, w_r1r, w_rspv, w_rsprdy, w_rspid, w_busy;
    logic [4:0]  w_r0op, w_r1op;
    logic [15:0] w_r0a, w_r0b, w_r1a, w_r1b, w_rspres;
    logic [3:0]  w_rspfl;

    ula_sched #(.WIDTH(3), .OPW(5)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(r0r), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(r1r), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b),
        .rsp_valid(rspv), .rsp_ready(rsprdy), .rsp_id(rspid), .rsp_result(rspres),
        .rsp_flags(rspfl), .busy(busy)
    );

    ula_sched #(.WIDTH(16), .OPW(5)) dut16 (
        .clk(clk), .rst(rst),
        .req0_valid(w_r0v), .req0_ready(w_r0r), .req0_op(w_r0op), .req0_a(w_r0a), .req0_b(w_r0b),
        .req1_valid(w_r1v), .req1_ready(w_r1r), .req1_op(w_r1op), .req1_a(w_r1a), .req1_b(w_r1b),
        .rsp_valid(w_rspv), .rsp_ready(w_rsprdy), .rsp_id(w_rspid), .rsp_result(w_rspres),
        .rsp_flags(w_rspfl), .busy(w_busy)
    );

    // Scenario 3 stimulus and hand-computed responses (flags are {O,C,S,Z})
    logic [4:0] t3_op0 [3] = '{OP_ADD, OP_ADD, OP_INC};
    logic [2:0] t3_a0  [3] = '{3'd1, 3'd3, 3'd7};
    logic [2:0] t3_b0  [3] = '{3'd1, 3'd1, 3'd0};
    logic [4:0] t3_op1 [3] = '{OP_ADDINC, OP_SUBDEC, OP_SUBDEC};
    logic [2:0] t3_a1  [3] = '{3'd2, 3'd5, 3'd3};
    logic [2:0] t3_b1  [3] = '{3'd2, 3'd2, 3'd3};
    logic       t3_eid [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] t3_eres[6] = '{3'b010, 3'b101, 3'b100, 3'b010, 3'b000, 3'b111};
    logic [3:0] t3_efl [6] = '{4'b0000, 4'b1010, 4'b1010, 4'b1100, 4'b0101, 4'b0010};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0v = 1'b0; r1v = 1'b0; rsprdy = 1'b0;
        w_r0v = 1'b0; w_r1v = 1'b0; w_rsprdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issue one op on the 3-bit instance and wait (bounded) for its response
    task automatic single_op(input logic who, input logic [4:0] op, input logic [2:0] a,
                             input logic [2:0] b, output int n_rdy, output int lat,
                             output logic got_id, output logic [2:0] got_res,
                             output logic [3:0] got_fl);
        int  rdy_at;
        bit  done;
        bit  hs;
        n_rdy = 0; lat = -1; rdy_at = -1; done = 0;
        got_id = 1'b0; got_res = '0; got_fl = '0;
        rsprdy = 1'b1;
        if (!who) begin r0v = 1'b1; r0op = op; r0a = a; r0b = b; end
        else      begin r1v = 1'b1; r1op = op; r1a = a; r1b = b; end
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            hs = r0r || r1r;
            if (hs) begin
                n_rdy++;
                if (rdy_at < 0) rdy_at = c;
            end
            if (rspv) begin
                lat = (rdy_at < 0) ? -1 : c - rdy_at;
                got_id = rspid; got_res = rspres; got_fl = rspfl;
                done = 1;
            end
            @(posedge clk); #1;
            if (hs) begin r0v = 1'b0; r1v = 1'b0; end
        end
    endtask

    initial begin
        int n_rdy, lat, ng, k, i0, i1, n_acc, last_acc, n_rsp;
        logic g0, g1, id, seen;
        logic [2:0] res;
        logic [3:0] fl;
        logic ord[6];

        r0op = '0; r0a = '0; r0b = '0; r1op = '0; r1a = '0; r1b = '0;
        w_r0op = '0; w_r0a = '0; w_r0b = '0; w_r1op = '0; w_r1a = '0; w_r1b = '0;

        // Reset values
        rst = 1'b1;
        r0v = 1'b0; r1v = 1'b0; rsprdy = 1'b0;
        w_r0v = 1'b0; w_r1v = 1'b0; w_rsprdy = 1'b0;
        @(negedge clk);
        check_eq("rst_rsp_valid", rspv, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_readies", {r0r, r1r}, 0);
        check_eq("rst_rsp_id", rspid, 0);
        check_eq("rst_result", rspres, 0);
        check_eq("rst_flags", rspfl, 0);
        check_eq("rst_result16", w_rspres, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: 001 + 111 wraps to zero with carry
        single_op(1'b0, OP_ADD, 3'b001, 3'b111, n_rdy, lat, id, res, fl);
        check_eq("t1_ready_pulses", n_rdy, 1);
        check_eq("t1_latency", lat, 2);
        check_eq("t1_id", id, 0);
        check_eq("t1_result", res, 3'b000);
        check_eq("t1_flags", fl, 4'b0101);

        // 2: 010 + 011 overflows into the sign bit
        single_op(1'b0, OP_ADD, 3'b010, 3'b011, n_rdy, lat, id, res, fl);
        check_eq("t2_latency", lat, 2);
        check_eq("t2_result", res, 3'b101);
        check_eq("t2_flags", fl, 4'b1010);

        // 3: both requesters busy from reset, three ops each
        do_reset();
        rsprdy = 1'b1;
        ng = 0; k = 0; i0 = 0; i1 = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            r0v = (i0 < 3);
            r1v = (i1 < 3);
            if (i0 < 3) begin r0op = t3_op0[i0]; r0a = t3_a0[i0]; r0b = t3_b0[i0]; end
            if (i1 < 3) begin r1op = t3_op1[i1]; r1a = t3_a1[i1]; r1b = t3_b1[i1]; end
            @(negedge clk);
            g0 = r0r; g1 = r1r;
            if (g0 && g1) check_eq("t3_dual_ready", {g1, g0}, 2'b01);
            if ((g0 || g1) && ng < 6) begin ord[ng] = g1; ng++; end
            if (rspv) begin
                check_eq($sformatf("t3_id%0d", k), rspid, t3_eid[k]);
                check_eq($sformatf("t3_res%0d", k), rspres, t3_eres[k]);
                check_eq($sformatf("t3_fl%0d", k), rspfl, t3_efl[k]);
                k++;
            end
            @(posedge clk); #1;
            if (g0) i0++;
            if (g1) i1++;
        end
        r0v = 1'b0; r1v = 1'b0;
        check_eq("t3_grants", ng, 6);
        check_eq("t3_responses", k, 6);
        for (int j = 0; j < ng; j++) check_eq($sformatf("t3_order%0d", j), ord[j], t3_eid[j]);

        // 4: backpressure in RESP while requester 1 waits
        r0v = 1'b1; r0op = OP_ADD; r0a = 3'd2; r0b = 3'd3; rsprdy = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk); seen = r0r;
            @(posedge clk); #1;
        end
        check_eq("t4_accept", seen, 1);
        r0v = 1'b0; r1v = 1'b1; r1op = OP_ADD; r1a = 3'd1; r1b = 3'd1;
        @(negedge clk);
        check_eq("t4_exec_r1_ready", r1r, 0);
        check_eq("t4_exec_busy", busy, 1);
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("t4_hold_valid", rspv, 1);
            check_eq("t4_hold_id", rspid, 0);
            check_eq("t4_hold_result", rspres, 3'b101);
            check_eq("t4_hold_flags", rspfl, 4'b1010);
            check_eq("t4_hold_r1_ready", r1r, 0);
            @(posedge clk); #1;
        end
        rsprdy = 1'b1;
        @(negedge clk);
        check_eq("t4_hs_valid", rspv, 1);
        check_eq("t4_hs_r1_ready", r1r, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("t4_next_r1_ready", r1r, 1);
        check_eq("t4_next_rsp_valid", rspv, 0);
        @(posedge clk); #1;
        r1v = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            if (rspv) begin
                seen = 1'b1;
                check_eq("t4_r1_id", rspid, 1);
                check_eq("t4_r1_result", rspres, 3'b010);
                check_eq("t4_r1_flags", rspfl, 4'b0000);
            end
            @(posedge clk); #1;
        end
        check_eq("t4_r1_response", seen, 1);

        // 5: reset while the op is in EXEC
        r0v = 1'b1; r0op = OP_ADD; r0a = 3'd1; r0b = 3'd1; rsprdy = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk); seen = r0r;
            @(posedge clk); #1;
        end
        check_eq("t5_accept", seen, 1);
        r0v = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_valid", rspv, 0);
        check_eq("t5_rst_out", {rspid, rspres, rspfl, r0r, r1r}, 0);
        @(negedge clk);
        rst = 1'b0;
        n_rsp = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rspv) n_rsp++;
        end
        check_eq("t5_dropped", n_rsp, 0);
        @(posedge clk); #1;
        single_op(1'b1, OP_ADDINC, 3'd2, 3'd2, n_rdy, lat, id, res, fl);
        check_eq("t5_after_latency", lat, 2);
        check_eq("t5_after_id", id, 1);
        check_eq("t5_after_result", res, 3'b101);
        check_eq("t5_after_flags", fl, 4'b1010);

        // 6: 16-bit increment held valid, full throughput
        w_r1v = 1'b1; w_r1op = OP_INC; w_r1a = 16'h7FFF; w_r1b = 16'h0000; w_rsprdy = 1'b1;
        n_acc = 0; last_acc = -1; n_rsp = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (w_r1r) begin
                if (last_acc >= 0) check_eq("t6_gap", c - last_acc, 3);
                last_acc = c;
                n_acc++;
            end
            if (w_rspv) begin
                check_eq("t6_result", w_rspres, 16'h8000);
                check_eq("t6_flags", w_rspfl, 4'b1010);
                check_eq("t6_id", w_rspid, 1);
                n_rsp++;
            end
            @(posedge clk); #1;
        end
        w_r1v = 1'b0;
        check_eq("t6_accepts", n_acc, 4);
        check_eq("t6_responses", n_rsp, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
